bf_scan_sequencer: RTL and testbench
====================================

// Module: bf_scan_sequencer
// PURPOSE
//  Frame-level scheduler for the delay-and-sum beamformer core (top_bf).
//  On frame_start it walks every focal point (line-major, depth-minor), drives x_f/z_f,
//  pulses the core's start and waits for its valid.
//  Each beamformed sample is forwarded downstream on a valid/ready pixel stream tagged with line/depth.
//  Sits between the imaging control registers and the beamformer core.
// PARAMETERS
//  COORD_W   16   width of x_f / z_f focal coordinates (matches core DATA_W)
//  OUT_W     18   width of core beamformed_output / pix_data
//  N_LINES   128  scan lines per frame (>=1)
//  N_DEPTHS  256  focal depths per line (>=1)
//  X_START   0    x_f of line 0;  X_STEP 1  x_f increment per line
//  Z_START   0    z_f of depth 0; Z_STEP 1  z_f increment per depth
//  TIMEOUT   1023 max cycles waiting for bf_valid (only with BF_SEQ_TIMEOUT_EN)
// PORTS
//  clk            in   1        system clock, all logic on rising edge
//  reset_n        in   1        asynchronous active-low reset
//  frame_start    in   1        1-cycle request to scan one frame; ignored while frame_busy
//  frame_busy     out  1        high from accepted frame_start until frame_done
//  frame_done     out  1        1-cycle pulse after last pixel handshake
//  bf_start       out  1        1-cycle start pulse to core
//  bf_x_f         out  COORD_W  focal x to core, stable from bf_start until bf_valid
//  bf_z_f         out  COORD_W  focal z to core, same stability rule
//  bf_valid       in   1        core result valid (sampled only in WAIT)
//  bf_out         in   OUT_W    core beamformed_output
//  pix_valid      out  1        pixel stream valid
//  pix_ready      in   1        pixel stream ready
//  pix_data       out  OUT_W    beamformed sample
//  pix_line       out  $clog2(N_LINES)   line index; pix_depth out $clog2(N_DEPTHS) depth index
//  pix_last       out  1        high with final pixel of frame
//  error_timeout  out  1        sticky watchdog flag, cleared by accepted frame_start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0, bf_x_f=X_START, bf_z_f=Z_START.
//  FSM IDLE->ISSUE->WAIT->EMIT->(ISSUE | DONE)->IDLE.
//   IDLE : frame_start -> load line=depth=0, coords=START, clear error_timeout, frame_busy=1, ->ISSUE.
//   ISSUE: bf_start=1 for exactly this cycle, ->WAIT.
//   WAIT : bf_valid -> capture bf_out into pix_data, ->EMIT. A bf_valid arriving in ISSUE is ignored.
//   EMIT : pix_valid=1, pix_data/line/depth/last held stable until pix_ready (no combinational ready->valid path).
//     On handshake: if last -> DONE. Else depth++, z_f+=Z_STEP.
//     On depth wrap (N_DEPTHS-1): depth=0, z_f=Z_START, line++, x_f+=X_STEP. Then ->ISSUE.
//   DONE : frame_done=1 one cycle, frame_busy=0, ->IDLE. frame_start in DONE is ignored.
//  Coordinate adds are unsigned modulo 2^COORD_W (wrap, no saturation).
//  Minimum per-pixel cost = 3 cycles + core latency + backpressure.
//  pix_last = (line==N_LINES-1 && depth==N_DEPTHS-1). N_LINES=N_DEPTHS=1 gives a single-pixel frame.
//  reset_n low mid-frame: immediate return to reset values; no frame_done; core restarted only by a new frame.
// CONFIGURATION
//  BF_SEQ_TIMEOUT_EN defined: WAIT counts cycles. At TIMEOUT without bf_valid: set error_timeout,
//    pix_data=0, ->EMIT. The frame continues, so pixel count always equals N_LINES*N_DEPTHS.
//  Undefined: WAIT blocks indefinitely; error_timeout tied 0; no counter logic.
// STRUCTURE
//  bf_seq_defs.vh: FSM state localparams (IDLE/ISSUE/WAIT/EMIT/DONE), index-width helpers.
//  Sub-module bf_seq_addr_gen: line/depth counters, x_f/z_f accumulators, last flag.
//    Controlled by load and advance strobes from the FSM.
// TESTING
//  1 N_LINES=2,N_DEPTHS=4,X_STEP=8,Z_STEP=4, core valid 5 cycles after start, pix_ready=1
//    -> 8 pixels. (x_f,z_f) sequence (0,0),(0,4),(0,8),(0,12),(8,0)...(8,12).
//    pix_last only on pixel 8; one frame_done.
//  2 Backpressure: pix_ready low 10 cycles on pixel 3 -> pix_valid/data/line/depth held constant;
//    no bf_start issued during stall.
//  3 frame_start pulsed mid-frame and in DONE -> ignored; frame_busy stays 1; exactly one frame_done.
//  4 TIMEOUT=16, BF_SEQ_TIMEOUT_EN, core never valid -> pixel emitted with data 0 after 16 WAIT cycles;
//    error_timeout=1 until next frame_start. Without macro -> FSM stays in WAIT.
//  5 reset_n asserted in EMIT of pixel 5 -> all outputs 0 asynchronously.
//    A new frame_start restarts at (X_START,Z_START) with line=depth=0.
//  6 X_START=16'hFFF8, X_STEP=8, N_LINES=2 -> line 1 x_f=16'h0000 (wrap).

Source files
------------

// File: rtl/bf_scan_sequencer_pkg.sv
// Shared definitions for the beamformer scan sequencer.
//   state_e : FSM state encoding (IDLE/ISSUE/WAIT/EMIT/DONE).
//   idx_w   : index width helper. It never returns 0, so a dimension of size 1
//             still gets a 1-bit index port.
// Optional feature macro used by the top: BF_SEQ_TIMEOUT_EN.
package bf_scan_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bf_scan_sequencer_addr_gen.sv
// Focal-point address generator for the scan sequencer.
// Walks line-major / depth-minor. Coordinate adds wrap modulo 2^COORD_W.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   load           restart at line=depth=0, (X_START, Z_START)
//   advance        step to the next focal point; the depth wrap bumps the line
//   line, depth    current indices
//   x_f, z_f       current focal coordinates
//   last           current point is the final one of the frame
module bf_scan_sequencer_addr_gen
   import bf_scan_sequencer_pkg::*;
#(
   parameter int                 COORD_W  = 16,
   parameter int                 N_LINES  = 128,
   parameter int                 N_DEPTHS = 256,
   parameter logic [COORD_W-1:0] X_START  = '0,
   parameter logic [COORD_W-1:0] X_STEP   = COORD_W'(1),
   parameter logic [COORD_W-1:0] Z_START  = '0,
   parameter logic [COORD_W-1:0] Z_STEP   = COORD_W'(1),
   parameter int                 LINE_W   = idx_w(N_LINES),
   parameter int                 DEPTH_W  = idx_w(N_DEPTHS)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic               advance,
   output logic [LINE_W-1:0]  line,
   output logic [DEPTH_W-1:0] depth,
   output logic [COORD_W-1:0] x_f,
   output logic [COORD_W-1:0] z_f,
   output logic               last
);

   localparam logic [LINE_W-1:0]  LINE_MAX  = LINE_W'(N_LINES - 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(N_DEPTHS - 1);

   logic [LINE_W-1:0]  line_q, line_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] z_q, z_d;

   always_comb begin
      line_d  = line_q;
      depth_d = depth_q;
      x_d     = x_q;
      z_d     = z_q;
      if (load) begin
         line_d  = '0;
         depth_d = '0;
         x_d     = X_START;
         z_d     = Z_START;
      end else if (advance) begin
         if (depth_q == DEPTH_MAX) begin
            // End of a line: rewind depth, move to the next line.
            depth_d = '0;
            z_d     = Z_START;
            line_d  = line_q + LINE_W'(1);
            x_d     = x_q + X_STEP;
         end else begin
            depth_d = depth_q + DEPTH_W'(1);
            z_d     = z_q + Z_STEP;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_q  <= '0;
         depth_q <= '0;
         x_q     <= X_START;
         z_q     <= Z_START;
      end else begin
         line_q  <= line_d;
         depth_q <= depth_d;
         x_q     <= x_d;
         z_q     <= z_d;
      end
   end

   assign line  = line_q;
   assign depth = depth_q;
   assign x_f   = x_q;
   assign z_f   = z_q;
   assign last  = (line_q == LINE_MAX) && (depth_q == DEPTH_MAX);

endmodule

// File: rtl/bf_scan_sequencer.sv
// Frame-level scheduler for the delay-and-sum beamformer core.
// On frame_start it visits every focal point and drives bf_x_f/bf_z_f. For each
// point it pulses bf_start and waits for bf_valid. Each result goes out on a
// pixel stream tagged with its line and depth.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   frame_start            request one frame; ignored unless idle
//   frame_busy, frame_done busy during the scan; 1-cycle done pulse
//   bf_start, bf_x_f/z_f   core start pulse and focal point (held until bf_valid)
//   bf_valid, bf_out       core result
//   pix_*                  pixel stream (data, line, depth, last)
//   error_timeout          sticky watchdog flag
//   dbg_state              current FSM state
//
// Pixel handshake: pix_valid rises only from registered state. Once raised,
// pix_valid, pix_data, pix_line, pix_depth and pix_last stay constant until a
// cycle where pix_ready is also high, and the transfer happens on that edge.
// pix_valid never depends combinationally on pix_ready.
//
// Macro BF_SEQ_TIMEOUT_EN: when defined, WAIT gives up after TIMEOUT cycles.
// It then sets error_timeout and emits a zero pixel. When not defined, WAIT
// blocks until bf_valid and error_timeout is tied low.
module bf_scan_sequencer
   import bf_scan_sequencer_pkg::*;
#(
   parameter int                 COORD_W  = 16,
   parameter int                 OUT_W    = 18,
   parameter int                 N_LINES  = 128,
   parameter int                 N_DEPTHS = 256,
   parameter logic [COORD_W-1:0] X_START  = '0,
   parameter logic [COORD_W-1:0] X_STEP   = COORD_W'(1),
   parameter logic [COORD_W-1:0] Z_START  = '0,
   parameter logic [COORD_W-1:0] Z_STEP   = COORD_W'(1),
   parameter int                 TIMEOUT  = 1023,
   localparam int                LINE_W   = idx_w(N_LINES),
   localparam int                DEPTH_W  = idx_w(N_DEPTHS)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               frame_start,
   output logic               frame_busy,
   output logic               frame_done,
   output logic               bf_start,
   output logic [COORD_W-1:0] bf_x_f,
   output logic [COORD_W-1:0] bf_z_f,
   input  logic               bf_valid,
   input  logic [OUT_W-1:0]   bf_out,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [OUT_W-1:0]   pix_data,
   output logic [LINE_W-1:0]  pix_line,
   output logic [DEPTH_W-1:0] pix_depth,
   output logic               pix_last,
   output logic               error_timeout,
   output logic [2:0]         dbg_state
);

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   pix_data_q, pix_data_d;
   logic               load, advance, last;

`ifdef BF_SEQ_TIMEOUT_EN
   localparam int               CNT_W    = idx_w(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             error_timeout_q, error_timeout_d;
`endif

   bf_scan_sequencer_addr_gen #(
      .COORD_W  (COORD_W),
      .N_LINES  (N_LINES),
      .N_DEPTHS (N_DEPTHS),
      .X_START  (X_START),
      .X_STEP   (X_STEP),
      .Z_START  (Z_START),
      .Z_STEP   (Z_STEP),
      .LINE_W   (LINE_W),
      .DEPTH_W  (DEPTH_W)
   ) u_addr_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .advance (advance),
      .line    (pix_line),
      .depth   (pix_depth),
      .x_f     (bf_x_f),
      .z_f     (bf_z_f),
      .last    (last)
   );

   always_comb begin
      state_d    = state_q;
      pix_data_d = pix_data_q;
      load       = 1'b0;
      advance    = 1'b0;
`ifdef BF_SEQ_TIMEOUT_EN
      wait_cnt_d      = wait_cnt_q;
      error_timeout_d = error_timeout_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               load    = 1'b1;
               state_d = ST_ISSUE;
`ifdef BF_SEQ_TIMEOUT_EN
               error_timeout_d = 1'b0;
`endif
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef BF_SEQ_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end
         ST_WAIT: begin
            if (bf_valid) begin
               pix_data_d = bf_out;
               state_d    = ST_EMIT;
            end
`ifdef BF_SEQ_TIMEOUT_EN
            // The frame still emits a (zero) pixel, so every frame carries
            // exactly N_LINES*N_DEPTHS pixels.
            else if (wait_cnt_q == CNT_LAST) begin
               pix_data_d      = '0;
               error_timeout_d = 1'b1;
               state_d         = ST_EMIT;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
`endif
         end
         ST_EMIT: begin
            if (pix_ready) begin
               if (last) begin
                  state_d = ST_DONE;
               end else begin
                  advance = 1'b1;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         pix_data_q <= '0;
      end else begin
         state_q    <= state_d;
         pix_data_q <= pix_data_d;
      end
   end

`ifdef BF_SEQ_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_q      <= '0;
         error_timeout_q <= 1'b0;
      end else begin
         wait_cnt_q      <= wait_cnt_d;
         error_timeout_q <= error_timeout_d;
      end
   end
   assign error_timeout = error_timeout_q;
`else
   assign error_timeout = 1'b0;
`endif

   assign frame_busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_EMIT);
   assign frame_done = (state_q == ST_DONE);
   assign bf_start   = (state_q == ST_ISSUE);
   assign pix_valid  = (state_q == ST_EMIT);
   assign pix_data   = pix_data_q;
   // Only meaningful while pix_valid. The index counters do not move in EMIT
   // until the handshake, so pix_last stays stable.
   assign pix_last   = last;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_bf_scan_sequencer.sv
// Testbench for bf_scan_sequencer. Main instance: 2 lines x 4 depths, x_f
// starts at 16'hFFF8 so that line 1 wraps to 0. Second instance: 1x1 frame.
module tb_bf_scan_sequencer;

   localparam int          NL   = 2;
   localparam int          ND   = 4;
   localparam int          LW   = 1;
   localparam int          DW   = 2;
   localparam int          OW   = 18;
   localparam int          PW   = OW + LW + DW + 1;
   localparam logic [15:0] X0   = 16'hFFF8;
   localparam int          XS   = 8;
   localparam int          ZS   = 4;
   localparam int          LAT  = 5;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   // main DUT signals
   logic          frame_start, frame_busy, frame_done, bf_start;
   logic [15:0]   bf_x_f, bf_z_f;
   logic          bf_valid;
   logic [OW-1:0] bf_out;
   logic          pix_valid, pix_ready, pix_last, error_timeout;
   logic [OW-1:0] pix_data;
   logic [LW-1:0] pix_line;
   logic [DW-1:0] pix_depth;
   logic [2:0]    dbg_state;

   // single-pixel DUT signals
   logic          fs1, busy1, done1, bst1, bv1, pv1, pr1, plast1, err1;
   logic [15:0]   x1, z1;
   logic [OW-1:0] bo1, pd1;
   logic [0:0]    pl1, pdep1;
   logic [2:0]    dbg1;

   bf_scan_sequencer #(
      .COORD_W(16), .OUT_W(OW), .N_LINES(NL), .N_DEPTHS(ND),
      .X_START(X0), .X_STEP(16'd8), .Z_START(16'd0), .Z_STEP(16'd4), .TIMEOUT(16)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .frame_busy(frame_busy),
      .frame_done(frame_done), .bf_start(bf_start), .bf_x_f(bf_x_f), .bf_z_f(bf_z_f),
      .bf_valid(bf_valid), .bf_out(bf_out), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_line(pix_line), .pix_depth(pix_depth), .pix_last(pix_last),
      .error_timeout(error_timeout), .dbg_state(dbg_state)
   );

   bf_scan_sequencer #(
      .COORD_W(16), .OUT_W(OW), .N_LINES(1), .N_DEPTHS(1), .TIMEOUT(16)
   ) u_one (
      .clk(clk), .reset_n(reset_n), .frame_start(fs1), .frame_busy(busy1),
      .frame_done(done1), .bf_start(bst1), .bf_x_f(x1), .bf_z_f(z1),
      .bf_valid(bv1), .bf_out(bo1), .pix_valid(pv1), .pix_ready(pr1),
      .pix_data(pd1), .pix_line(pl1), .pix_depth(pdep1), .pix_last(plast1),
      .error_timeout(err1), .dbg_state(dbg1)
   );

   // scoreboard state
   logic [PW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int pix_cnt, done_cnt, start_cnt, iss_idx, epoch;
   bit core_silent;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // One clock: sample and score at the negedge, then return 1 time unit past
   // the next posedge, where the caller drives inputs.
   task automatic tick();
      logic [PW-1:0] e;
      @(negedge clk);
      if (reset_n) begin
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) check("pix_unexpected", pix_valid, 1'b0);
            else begin
               e = exp_q.pop_front();
               check("pixel", {pix_data, pix_line, pix_depth, pix_last}, e);
               pix_cnt++;
            end
         end
         if (frame_done) done_cnt++;
         if (bf_start) start_cnt++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame();
      iss_idx = 0; pix_cnt = 0; done_cnt = 0; start_cnt = 0;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_pix(input int n);
      int c = 0;
      while (pix_cnt < n && c < 400) begin tick(); c++; end
      check("wait_pix_budget", pix_cnt >= n, 1'b1);
   endtask

   task automatic wait_valid();
      int c = 0;
      while (!pix_valid && c < 100) begin tick(); c++; end
      check("wait_valid_budget", pix_valid, 1'b1);
   endtask

   task automatic run_to_done();
      int c = 0;
      while (!frame_done && c < 600) begin tick(); c++; end
      check("reach_done", frame_done, 1'b1);
   endtask

   // Core model: checks the focal point against the expected scan order and
   // answers LAT cycles after each bf_start with random data.
   initial begin
      int unsigned   l, d;
      int            ep;
      logic [15:0]   ex, ez;
      logic [OW-1:0] dat;
      bit            lst;
      bf_valid = 1'b0;
      bf_out   = '0;
      forever begin
         @(negedge clk);
         if (bf_start && reset_n) begin
            l  = iss_idx / ND;
            d  = iss_idx % ND;
            iss_idx++;
            ex = X0 + 16'(l * XS);
            ez = 16'(d * ZS);
            lst = (l == NL - 1) && (d == ND - 1);
            check("bf_x_f", bf_x_f, ex);
            check("bf_z_f", bf_z_f, ez);
            ep = epoch;
            if (core_silent) begin
`ifdef BF_SEQ_TIMEOUT_EN
               exp_q.push_back({{OW{1'b0}}, LW'(l), DW'(d), lst});
`endif
            end else begin
               repeat (LAT) @(posedge clk);
               #1;
               if (ep == epoch && reset_n) begin
                  check("x_hold", {bf_x_f, bf_z_f}, {ex, ez});
                  dat = OW'($urandom_range(0, 262143));
                  bf_valid = 1'b1;
                  bf_out   = dat;
                  exp_q.push_back({dat, LW'(l), DW'(d), lst});
                  @(posedge clk);
                  #1;
                  bf_valid = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [PW-1:0] snap;
      int            sc, n;
      reset_n = 1'b0; frame_start = 1'b0; pix_ready = 1'b1; core_silent = 1'b0;
      epoch = 0; iss_idx = 0; pix_cnt = 0; done_cnt = 0; start_cnt = 0;
      fs1 = 1'b0; bv1 = 1'b0; bo1 = '0; pr1 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      // reset values
      check("rst_busy", frame_busy, 1'b0);
      check("rst_done", frame_done, 1'b0);
      check("rst_bf_start", bf_start, 1'b0);
      check("rst_pix_valid", pix_valid, 1'b0);
      check("rst_err", error_timeout, 1'b0);
      check("rst_pix", {pix_data, pix_line, pix_depth, pix_last}, '0);
      check("rst_coords", {bf_x_f, bf_z_f}, {X0, 16'd0});
      check("rst_state", dbg_state, 3'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      tick();

      // frame 1: full scan, x wrap on line 1, stall on pixel 3, ignored pokes
      start_frame();
      check("busy_after_start", frame_busy, 1'b1);
      wait_pix(2);
      pix_ready = 1'b0;
      wait_valid();
      snap = {pix_data, pix_line, pix_depth, pix_last};
      check("stall_pix3_index", {pix_line, pix_depth}, {1'b0, 2'd2});
      sc = start_cnt;
      for (int i = 0; i < 10; i++) begin
         if (i == 5) frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
         check("stall_hold", {pix_valid, pix_data, pix_line, pix_depth, pix_last}, {1'b1, snap});
      end
      check("stall_no_bf_start", start_cnt, sc);
      check("busy_mid_frame", frame_busy, 1'b1);
      pix_ready = 1'b1;
      run_to_done();
      frame_start = 1'b1;   // sampled while in DONE
      tick();
      frame_start = 1'b0;
      repeat (4) tick();
      check("f1_idle_busy", frame_busy, 1'b0);
      check("f1_idle_state", dbg_state, 3'd0);
      check("f1_done_count", done_cnt, 1);
      check("f1_pix_count", pix_cnt, NL * ND);
      check("f1_start_count", start_cnt, NL * ND);
      check("f1_queue_empty", exp_q.size(), 0);

      // frame 2: reset while pixel 5 is on the stream
      start_frame();
      wait_pix(4);
      pix_ready = 1'b0;
      wait_valid();
      reset_n = 1'b0;
      #1;
      check("arst_pix_valid", pix_valid, 1'b0);
      check("arst_busy", frame_busy, 1'b0);
      check("arst_pix", {pix_data, pix_line, pix_depth, pix_last}, '0);
      check("arst_coords", {bf_x_f, bf_z_f}, {X0, 16'd0});
      check("arst_state", dbg_state, 3'd0);
      epoch++;
      exp_q.delete();
      pix_ready = 1'b1;
      tick(); tick();
      reset_n = 1'b1;
      tick();
      check("arst_no_done", done_cnt, 0);

      // frame 3: clean restart from the start point
      start_frame();
      run_to_done();
      tick();
      check("f3_pix_count", pix_cnt, NL * ND);
      check("f3_done_count", done_cnt, 1);

      // silent core
      core_silent = 1'b1;
      start_frame();
`ifdef BF_SEQ_TIMEOUT_EN
      n = 0;
      while (!pix_valid && n < 100) begin tick(); n++; end
      check("timeout_latency", n, 17);
      check("timeout_data", pix_data, '0);
      run_to_done();
      tick();
      check("timeout_pix_count", pix_cnt, NL * ND);
      check("timeout_flag", error_timeout, 1'b1);
      repeat (3) tick();
      check("timeout_flag_sticky", error_timeout, 1'b1);
      core_silent = 1'b0;
      start_frame();
      check("timeout_flag_clear", error_timeout, 1'b0);
      run_to_done();
      tick();
      check("after_timeout_pix", pix_cnt, NL * ND);
`else
      n = 0;
      repeat (40) tick();
      check("nowd_pix_valid", pix_valid, 1'b0);
      check("nowd_busy", frame_busy, 1'b1);
      check("nowd_state", dbg_state, 3'd2);
      check("nowd_starts", start_cnt, 1);
      check("nowd_err", error_timeout, 1'b0);
      reset_n = 1'b0;
      epoch++;
      exp_q.delete();
      tick(); tick();
      reset_n = 1'b1;
      core_silent = 1'b0;
      tick();
`endif

      // single-pixel frame on the 1x1 instance
      fs1 = 1'b1;
      tick();
      fs1 = 1'b0;
      check("one_start", {bst1, x1, z1}, {1'b1, 32'd0});
      tick();
      bv1 = 1'b1;
      bo1 = 18'h2A5C3;
      tick();
      bv1 = 1'b0;
      check("one_pixel", {pv1, pd1, pl1, pdep1, plast1}, {1'b1, 18'h2A5C3, 1'b0, 1'b0, 1'b1});
      tick();
      check("one_done", {done1, busy1}, {1'b1, 1'b0});
      tick();
      check("one_idle", {done1, busy1, pv1}, 3'b000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
